// File: rtl/core_multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I core: opcode classes, funct3 codes,
// FSM states and ALU operations.
package core_multicycle_pkg;

   localparam logic [6:0] CLASS_OP_IMM = 7'b0010011;
   localparam logic [6:0] CLASS_OP     = 7'b0110011;
   localparam logic [6:0] CLASS_LUI    = 7'b0110111;
   localparam logic [6:0] CLASS_AUIPC  = 7'b0010111;
   localparam logic [6:0] CLASS_JAL    = 7'b1101111;
   localparam logic [6:0] CLASS_JALR   = 7'b1100111;
   localparam logic [6:0] CLASS_BRANCH = 7'b1100011;
   localparam logic [6:0] CLASS_LOAD   = 7'b0000011;
   localparam logic [6:0] CLASS_STORE  = 7'b0100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   // alt is IR[30]; it selects SUB only when sub_ok (register-register form)
   function automatic alu_op_t alu_op_from_f3(logic [2:0] f3, logic alt, logic sub_ok);
      alu_op_t op;
      case (f3)
         F3_ADD:  op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/core_multicycle_alu.sv
// Integer ALU for the multi-cycle core; compare flags feed branch resolution.
module core_multicycle_alu
   import core_multicycle_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  alu_op_t           op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [XLEN-1:0]   result,
   output logic              eq,
   output logic              lt,
   output logic              ltu
);

   assign eq  = (a == b);
   assign lt  = ($signed(a) < $signed(b));
   assign ltu = (a < b);

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << b[4:0];
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> b[4:0];
         ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/core_multicycle.sv
// Multi-cycle RV32I-subset core with req/ack instruction and data ports.
//  state | meaning
//  FETCH | imem_req high, wait for imem_ack, capture IR
//  EXEC  | decode, ALU/jump/branch retire here; loads/stores latch request
//  MEM   | dmem_req high with latched fields until dmem_ack
//  HALT  | illegal or misaligned instruction seen; left only by reset
module core_multicycle
   import core_multicycle_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            n_rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_wstrb,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            halted,
   output logic            retire
);

   if (XLEN != 32) begin : g_xlen_check
      $error("core_multicycle supports XLEN=32 only");
   end

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic              imem_req_q, imem_req_d;
   logic              dmem_req_q, dmem_req_d;
   logic              dmem_we_q, dmem_we_d;
   logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
   logic [3:0]        dmem_wstrb_q, dmem_wstrb_d;
   logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
   logic [1:0]        mem_lane_q, mem_lane_d;
   logic [2:0]        mem_f3_q, mem_f3_d;
   logic              halted_q, halted_d;
   logic              retire_q, retire_d;
   logic [XLEN-1:0]   rf_q [32];

   logic [6:0]        opcode;
   logic [4:0]        rd, rs1, rs2;
   logic [2:0]        f3;
   logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0]   rs1_val, rs2_val;
   logic [XLEN-1:0]   pc_plus4, br_tgt, br_next, jal_tgt, jalr_tgt, ls_addr;
   alu_op_t           alu_op;
   logic [XLEN-1:0]   alu_a, alu_b, alu_res;
   logic              alu_eq, alu_lt, alu_ltu;
   logic              br_taken, br_f3_ok;
   logic              ls_ok, ls_misalign;
   logic [3:0]        st_wstrb;
   logic [XLEN-1:0]   st_wdata, ld_word, ld_val;
   logic              rf_we;
   logic [XLEN-1:0]   rf_wdata;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign f3     = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign imm_u  = {ir_q[31:12], 12'b0};
   assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

   assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

   assign pc_plus4 = pc_q + 32'd4;
   assign br_tgt   = pc_q + imm_b;
   assign jal_tgt  = pc_q + imm_j;
   assign jalr_tgt = (rs1_val + imm_i) & ~32'd1;
   assign ls_addr  = rs1_val + ((opcode == CLASS_STORE) ? imm_s : imm_i);
   assign br_next  = br_taken ? br_tgt : pc_plus4;

   always_comb begin
      alu_a  = rs1_val;
      alu_b  = rs2_val;
      alu_op = ALU_ADD;
      case (opcode)
         CLASS_OP_IMM: begin
            alu_b  = imm_i;
            alu_op = alu_op_from_f3(f3, ir_q[30], 1'b0);
         end
         CLASS_OP:     alu_op = alu_op_from_f3(f3, ir_q[30], 1'b1);
         CLASS_LUI: begin
            alu_a = '0;
            alu_b = imm_u;
         end
         CLASS_AUIPC: begin
            alu_a = pc_q;
            alu_b = imm_u;
         end
         default: ;
      endcase
   end

   core_multicycle_alu #(.XLEN(XLEN)) u_alu (
      .op     (alu_op),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_res),
      .eq     (alu_eq),
      .lt     (alu_lt),
      .ltu    (alu_ltu)
   );

   always_comb begin
      br_taken = 1'b0;
      br_f3_ok = 1'b1;
      case (f3)
         F3_BEQ:  br_taken = alu_eq;
         F3_BNE:  br_taken = !alu_eq;
         F3_BLT:  br_taken = alu_lt;
         F3_BGE:  br_taken = !alu_lt;
         F3_BLTU: br_taken = alu_ltu;
         F3_BGEU: br_taken = !alu_ltu;
         default: br_f3_ok = 1'b0;
      endcase
   end

   // Access legality, store lane enables and replicated store data
   always_comb begin
      ls_ok       = 1'b1;
      ls_misalign = 1'b0;
      case (f3)
         F3_B, F3_BU: ;
         F3_H, F3_HU: ls_misalign = ls_addr[0];
         F3_W:        ls_misalign = |ls_addr[1:0];
         default:     ls_ok = 1'b0;
      endcase
      if (opcode == CLASS_STORE && f3[2]) ls_ok = 1'b0;
      case (f3[1:0])
         2'b00: begin
            st_wstrb = 4'b0001 << ls_addr[1:0];
            st_wdata = {4{rs2_val[7:0]}};
         end
         2'b01: begin
            st_wstrb = 4'b0011 << ls_addr[1:0];
            st_wdata = {2{rs2_val[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = rs2_val;
         end
      endcase
   end

   assign ld_word = dmem_rdata >> {mem_lane_q, 3'b000};

   always_comb begin
      case (mem_f3_q)
         F3_B:    ld_val = {{(XLEN-8){ld_word[7]}}, ld_word[7:0]};
         F3_H:    ld_val = {{(XLEN-16){ld_word[15]}}, ld_word[15:0]};
         F3_BU:   ld_val = {{(XLEN-8){1'b0}}, ld_word[7:0]};
         F3_HU:   ld_val = {{(XLEN-16){1'b0}}, ld_word[15:0]};
         default: ld_val = ld_word;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wstrb_d = dmem_wstrb_q;
      dmem_wdata_d = dmem_wdata_q;
      mem_lane_d   = mem_lane_q;
      mem_f3_d     = mem_f3_q;
      retire_d     = 1'b0;
      rf_we        = 1'b0;
      rf_wdata     = alu_res;
      case (state_q)
         FETCH: begin
            if (imem_req_q && imem_ack) begin
               ir_d    = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = HALT;
            case (opcode)
               CLASS_OP_IMM, CLASS_OP, CLASS_LUI, CLASS_AUIPC: begin
                  rf_we    = 1'b1;
                  pc_d     = pc_plus4;
                  retire_d = 1'b1;
                  state_d  = FETCH;
               end
               CLASS_JAL, CLASS_JALR: begin
                  if (!((opcode == CLASS_JAL) ? jal_tgt[1] : jalr_tgt[1])) begin
                     rf_we    = 1'b1;
                     rf_wdata = pc_plus4;
                     pc_d     = (opcode == CLASS_JAL) ? jal_tgt : jalr_tgt;
                     retire_d = 1'b1;
                     state_d  = FETCH;
                  end
               end
               CLASS_BRANCH: begin
                  if (br_f3_ok && !br_next[1]) begin
                     pc_d     = br_next;
                     retire_d = 1'b1;
                     state_d  = FETCH;
                  end
               end
               CLASS_LOAD, CLASS_STORE: begin
                  if (ls_ok && !ls_misalign) begin
                     dmem_we_d    = (opcode == CLASS_STORE);
                     dmem_addr_d  = {ls_addr[XLEN-1:2], 2'b00};
                     dmem_wstrb_d = (opcode == CLASS_STORE) ? st_wstrb : 4'b0000;
                     dmem_wdata_d = (opcode == CLASS_STORE) ? st_wdata : '0;
                     mem_lane_d   = ls_addr[1:0];
                     mem_f3_d     = f3;
                     state_d      = MEM;
                  end
               end
               default: ;
            endcase
         end
         MEM: begin
            if (dmem_req_q && dmem_ack) begin
               if (!dmem_we_q) begin
                  rf_we    = 1'b1;
                  rf_wdata = ld_val;
               end
               pc_d     = pc_plus4;
               retire_d = 1'b1;
               state_d  = FETCH;
            end
         end
         default: state_d = HALT;
      endcase
      halted_d   = halted_q | (state_d == HALT);
      imem_req_d = (state_d == FETCH);
      dmem_req_d = (state_d == MEM);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         ir_q         <= '0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wstrb_q <= '0;
         dmem_wdata_q <= '0;
         mem_lane_q   <= '0;
         mem_f3_q     <= '0;
         halted_q     <= 1'b0;
         retire_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wstrb_q <= dmem_wstrb_d;
         dmem_wdata_q <= dmem_wdata_d;
         mem_lane_q   <= mem_lane_d;
         mem_f3_q     <= mem_f3_d;
         halted_q     <= halted_d;
         retire_q     <= retire_d;
      end
   end

   // Writes are suppressed during reset so an aborted instruction leaves no trace
   always_ff @(posedge clk) begin
      if (n_rst && rf_we && rd != 5'd0) rf_q[rd] <= rf_wdata;
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wstrb = dmem_wstrb_q;
   assign dmem_wdata = dmem_wdata_q;
   assign halted     = halted_q;
   assign retire     = retire_q;

endmodule

// File: tb/tb_core_multicycle.sv
// Directed bench for core_multicycle: small programs run from a behavioural
// instruction/data memory, with hand-computed expected stores, fetches and counts.
module tb_core_multicycle;

   logic        clk, n_rst;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, retire;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;

   logic [31:0] prog [64];
   int          i_lat, d_lat, i_wait, d_wait;
   bit          force_iack;
   logic [31:0] load_data;
   logic [31:0] fetch_log [$];
   logic [31:0] st_addr [$];
   logic [31:0] st_data [$];
   logic [3:0]  st_strb [$];
   int          retire_cnt, dreq_cycles;
   int          n_chk, n_pass;
   int          sb, rb, fb, db;

   core_multicycle #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wstrb (dmem_wstrb),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .halted     (halted),
      .retire     (retire)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: acks are set up on the falling edge for the next rising edge
   initial begin
      imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
      i_wait = 0; d_wait = 0;
      forever begin
         @(negedge clk);
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         if (force_iack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'h0000_0013;
         end else if (n_rst && imem_req) begin
            if (i_wait >= i_lat) begin
               imem_ack   = 1'b1;
               imem_rdata = prog[imem_addr[7:2]];
               fetch_log.push_back(imem_addr);
               i_wait = 0;
            end else i_wait++;
         end else i_wait = 0;
         if (n_rst && dmem_req) begin
            if (d_wait >= d_lat) begin
               dmem_ack   = 1'b1;
               dmem_rdata = load_data;
               if (dmem_we) begin
                  st_addr.push_back(dmem_addr);
                  st_data.push_back(dmem_wdata);
                  st_strb.push_back(dmem_wstrb);
               end
               d_wait = 0;
            end else d_wait++;
         end else d_wait = 0;
      end
   end

   initial begin
      retire_cnt = 0; dreq_cycles = 0;
      forever begin
         @(negedge clk);
         if (retire) retire_cnt++;
         if (dmem_req) dreq_cycles++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic clear_prog();
      for (int k = 0; k < 64; k++) prog[k] = 32'h0;
   endtask

   task automatic snap();
      sb = st_data.size(); rb = retire_cnt; fb = fetch_log.size(); db = dreq_cycles;
   endtask

   task automatic do_reset(input bit ack_during);
      n_rst = 1'b0;
      force_iack = ack_during;
      repeat (3) begin
         @(posedge clk); #1;
         if (ack_during) chk("rst_imem_req", 32'(imem_req), 32'h0);
      end
      force_iack = 1'b0;
      n_rst = 1'b1;
   endtask

   task automatic run_until_halt(input int max);
      int n;
      n = 0;
      while (!halted && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      chk("halt_reached", 32'(halted), 32'h1);
   endtask

   initial begin
      logic [31:0] exp_f [9];
      int n;
      n_chk = 0; n_pass = 0;
      n_rst = 1'b0; force_iack = 1'b0; i_lat = 0; d_lat = 0; load_data = '0;

      // Reset with ack held high, then ADDI/SRAI/SUB dumped by SW
      clear_prog();
      prog[0] = enc_i(-5, 0, 3'b000, 1, 7'h13);
      prog[1] = enc_i(32'h401, 1, 3'b101, 2, 7'h13);
      prog[2] = enc_r(7'h20, 1, 0, 3'b000, 3);
      prog[3] = enc_s(0, 1, 0, 3'b010);
      prog[4] = enc_s(4, 2, 0, 3'b010);
      prog[5] = enc_s(8, 3, 0, 3'b010);
      i_lat = 1; d_lat = 0;
      snap();
      do_reset(1'b1);
      @(posedge clk); #1;
      chk("post_rst_imem_req", 32'(imem_req), 32'h1);
      chk("post_rst_imem_addr", imem_addr, 32'h0);
      chk("post_rst_halted", 32'(halted), 32'h0);
      chk("post_rst_dmem_req", 32'(dmem_req), 32'h0);
      run_until_halt(400);
      chk("alu_retires", 32'(retire_cnt - rb), 32'd6);
      chk("alu_nstores", 32'(st_data.size() - sb), 32'd3);
      chk("addi_x1", st_data[sb], 32'hFFFF_FFFB);
      chk("srai_x2", st_data[sb+1], 32'hFFFF_FFFD);
      chk("sub_x3", st_data[sb+2], 32'h0000_0005);
      chk("sw_addr", st_addr[sb+2], 32'h0000_0008);

      // SB to a byte in lane 3 with a 3-cycle data memory
      clear_prog();
      prog[0] = {20'h12345, 5'd5, 7'b0110111};
      prog[1] = enc_i(32'h6AB, 5, 3'b000, 5, 7'h13);
      prog[2] = enc_i(32'h103, 0, 3'b000, 6, 7'h13);
      prog[3] = enc_s(0, 5, 6, 3'b000);
      i_lat = 0; d_lat = 2;
      snap();
      do_reset(1'b0);
      run_until_halt(400);
      chk("sb_nstores", 32'(st_data.size() - sb), 32'd1);
      chk("sb_addr", st_addr[sb], 32'h0000_0100);
      chk("sb_wstrb", 32'(st_strb[sb]), 32'h8);
      chk("sb_wdata", st_data[sb], 32'hABAB_ABAB);
      chk("sb_req_cycles", 32'(dreq_cycles - db), 32'd3);
      chk("sb_retires", 32'(retire_cnt - rb), 32'd4);

      // Sign/zero-extending sub-word loads from lane 2, and rd=x0
      clear_prog();
      prog[0] = enc_i(32'h102, 0, 3'b000, 6, 7'h13);
      prog[1] = enc_i(0, 6, 3'b000, 7, 7'h03);
      prog[2] = enc_i(0, 6, 3'b100, 8, 7'h03);
      prog[3] = enc_i(0, 6, 3'b000, 0, 7'h03);
      prog[4] = enc_i(0, 6, 3'b001, 9, 7'h03);
      prog[5] = enc_s(0, 7, 0, 3'b010);
      prog[6] = enc_s(4, 8, 0, 3'b010);
      prog[7] = enc_s(8, 0, 0, 3'b010);
      prog[8] = enc_s(12, 9, 0, 3'b010);
      d_lat = 1; load_data = 32'h0080_0000;
      snap();
      do_reset(1'b0);
      run_until_halt(600);
      chk("ld_nstores", 32'(st_data.size() - sb), 32'd4);
      chk("lb_sext", st_data[sb], 32'hFFFF_FF80);
      chk("lbu_zext", st_data[sb+1], 32'h0000_0080);
      chk("ld_x0", st_data[sb+2], 32'h0000_0000);
      chk("lh_lane2", st_data[sb+3], 32'h0000_0080);

      // BLT taken, BLTU not taken, JAL link, misaligned JALR target halts
      clear_prog();
      prog[0]  = enc_i(-1, 0, 3'b000, 1, 7'h13);
      prog[1]  = enc_i(1, 0, 3'b000, 2, 7'h13);
      prog[2]  = enc_j(32'h38, 0);
      prog[16] = enc_b(8, 2, 1, 3'b100);
      prog[18] = enc_b(8, 2, 1, 3'b110);
      prog[19] = enc_j(4, 11);
      prog[20] = enc_i(32'h100, 0, 3'b000, 2, 7'h13);
      prog[21] = enc_s(0, 11, 0, 3'b010);
      prog[22] = enc_i(3, 2, 3'b000, 1, 7'h67);
      prog[23] = enc_s(4, 1, 0, 3'b010);
      i_lat = 2; d_lat = 0;
      exp_f = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58};
      snap();
      do_reset(1'b0);
      run_until_halt(600);
      chk("br_nfetch", 32'(fetch_log.size() - fb), 32'd9);
      for (int k = 0; k < 9; k++) chk($sformatf("fetch%0d", k), fetch_log[fb+k], exp_f[k]);
      chk("jal_link", st_data[sb], 32'h0000_0050);
      chk("br_nstores", 32'(st_data.size() - sb), 32'd1);
      chk("br_retires", 32'(retire_cnt - rb), 32'd8);
      chk("jalr_pc_frozen", imem_addr, 32'h0000_0058);
      chk("jalr_no_req", 32'(imem_req), 32'h0);

      // Misaligned LW halts without a data request
      clear_prog();
      prog[0] = enc_i(6, 0, 3'b000, 1, 7'h13);
      prog[1] = enc_i(0, 1, 3'b010, 2, 7'h03);
      i_lat = 0;
      snap();
      do_reset(1'b0);
      run_until_halt(200);
      chk("lw_mis_dreq", 32'(dreq_cycles - db), 32'd0);
      chk("lw_mis_retires", 32'(retire_cnt - rb), 32'd1);

      // All-zero opcode halts immediately
      clear_prog();
      snap();
      do_reset(1'b0);
      run_until_halt(100);
      chk("illegal_retires", 32'(retire_cnt - rb), 32'd0);
      chk("illegal_nfetch", 32'(fetch_log.size() - fb), 32'd1);

      // Reset during an outstanding store aborts it
      clear_prog();
      prog[0] = enc_s(0, 0, 0, 3'b010);
      d_lat = 20;
      snap();
      do_reset(1'b0);
      n = 0;
      while (!dmem_req && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mem_req_seen", 32'(dmem_req), 32'h1);
      repeat (2) begin
         @(posedge clk); #1;
      end
      n_rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_mem_req", 32'(dmem_req), 32'h0);
      chk("rst_mid_mem_we", 32'(dmem_we), 32'h0);
      n_rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_nstores", 32'(st_data.size() - sb), 32'd0);
      chk("restart_imem_req", 32'(imem_req), 32'h1);
      chk("restart_imem_addr", imem_addr, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
